// File: rtl/gf_clmul_seq.sv
// gf_clmul_seq: sequential shift-and-XOR carry-less multiplier over GF(2)[x].
// Multiplies two operands of runtime grade m (2..DATA_WIDTH), one multiplier
// bit per cycle, and emits the unreduced 2m-1 bit product zero-extended to
// 2*DATA_WIDTH bits. Grade and primitive polynomial travel with the product.
//
// Optional build macro: GF_CLMUL_EARLY_TERM_EN
//   defined   - MUL ends as soon as the remaining multiplier bits are all zero
//   undefined - MUL always runs m iterations (fixed latency)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   a_in, b_in        multiplicand / multiplier
//   polyn_grade       field grade m
//   polyn_red_in      primitive polynomial (pass-through)
//   out_valid/out_ready output handshake
//   reduc_out         unreduced product
//   polyn_grade_out   captured grade
//   polyn_red_out     captured polynomial
//   grade_err         captured grade was out of range
module gf_clmul_seq #(
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           a_in,
    input  logic [DATA_WIDTH-1:0]           b_in,
    input  logic [$clog2(DATA_WIDTH):0]     polyn_grade,
    input  logic [DATA_WIDTH:0]             polyn_red_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*DATA_WIDTH-1:0]         reduc_out,
    output logic [$clog2(DATA_WIDTH):0]     polyn_grade_out,
    output logic [DATA_WIDTH:0]             polyn_red_out,
    output logic                            grade_err
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned RW = DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_a_sh, w_a_sh_nxt;
    logic [DW-1:0]   r_b_sh, w_b_sh_nxt;
    logic [PW-1:0]   r_acc, w_acc_nxt;
    logic [GW-1:0]   r_cnt, w_cnt_nxt;
    logic [GW-1:0]   r_grade, w_grade_nxt;
    logic [RW-1:0]   r_poly, w_poly_nxt;
    logic            r_err, w_err_nxt;
    logic            r_in_ready, w_in_ready_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    logic [DW-1:0]   w_mask;
    logic            w_grade_ok;
    logic            w_last;

    // Operand mask: keep bits below the runtime grade m.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(DW); i++) begin
            w_mask[i] = (polyn_grade > GW'(i));
        end
    end

    assign w_grade_ok = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(DW));

    // Final iteration detect; early-terminate build also stops once the
    // post-shift multiplier is empty, since no further XORs can occur.
    always_comb begin
`ifdef GF_CLMUL_EARLY_TERM_EN
        w_last = (r_cnt == GW'(1)) || ((r_b_sh >> 1) == '0);
`else
        w_last = (r_cnt == GW'(1));
`endif
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_a_sh_nxt      = r_a_sh;
        w_b_sh_nxt      = r_b_sh;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_grade_nxt     = r_grade;
        w_poly_nxt      = r_poly;
        w_err_nxt       = r_err;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_a_sh_nxt  = {DW'(0), a_in & w_mask};
                    w_b_sh_nxt  = b_in & w_mask;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = polyn_grade;
                    w_grade_nxt = polyn_grade;
                    w_poly_nxt  = polyn_red_in;
                    w_err_nxt   = !w_grade_ok;
                    w_state_nxt = w_grade_ok ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (r_b_sh[0]) begin
                    w_acc_nxt = r_acc ^ r_a_sh;
                end
                w_a_sh_nxt = r_a_sh << 1;
                w_b_sh_nxt = r_b_sh >> 1;
                w_cnt_nxt  = r_cnt - GW'(1);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // out_valid rises one edge after entering DONE.
                if (!r_out_valid) begin
                    w_out_valid_nxt = 1'b1;
                end else if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        w_in_ready_nxt = (w_state_nxt == S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_grade     <= '0;
            r_poly      <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_a_sh      <= w_a_sh_nxt;
            r_b_sh      <= w_b_sh_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grade     <= w_grade_nxt;
            r_poly      <= w_poly_nxt;
            r_err       <= w_err_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign reduc_out       = r_acc;
    assign polyn_grade_out = r_grade;
    assign polyn_red_out   = r_poly;
    assign grade_err       = r_err;

endmodule

// File: tb/tb_gf_clmul_seq.sv
// Directed testbench for gf_clmul_seq (DATA_WIDTH=4).
module tb_gf_clmul_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [2:0] polyn_grade;
    logic [4:0] polyn_red_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] reduc_out;
    logic [2:0] polyn_grade_out;
    logic [4:0] polyn_red_out;
    logic       grade_err;

    int errors = 0;
    int checks = 0;

    gf_clmul_seq #(.DATA_WIDTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .a_in            (a_in),
        .b_in            (b_in),
        .polyn_grade     (polyn_grade),
        .polyn_red_in    (polyn_red_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .reduc_out       (reduc_out),
        .polyn_grade_out (polyn_grade_out),
        .polyn_red_out   (polyn_red_out),
        .grade_err       (grade_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected edges from accept to out_valid for a valid grade.
    function automatic int exp_lat(input int m, input int b);
        int bm;
        int hb;
        bm = b & ((1 << m) - 1);
        hb = 0;
        for (int i = 0; i < 4; i++) if (bm[i]) hb = i;
`ifdef GF_CLMUL_EARLY_TERM_EN
        return hb + 2;
`else
        return m + 1;
`endif
    endfunction

    // Issue one operation with out_ready low; returns edges to out_valid (-1 on timeout).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] m, input logic [4:0] p, output int lat);
        @(negedge clk);
        out_ready    = 1'b0;
        a_in         = a;
        b_in         = b;
        polyn_grade  = m;
        polyn_red_in = p;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    // Complete the output handshake in one cycle.
    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, grade_err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, grade_err});
        end
        checks++;
        if ({reduc_out, polyn_grade_out, polyn_red_out} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0000", {reduc_out, polyn_grade_out, polyn_red_out});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run_op(4'hB, 4'h6, 3'd4, 5'h13, lat);
        checks++;
        if (lat !== exp_lat(4, 6)) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(4, 6));
        end
        checks++;
        if (reduc_out !== 8'h3A) begin
            errors++;
            $display("FAIL basic_product: got %h expected 3a", reduc_out);
        end
        checks++;
        if ({polyn_grade_out, polyn_red_out, grade_err, in_ready} !== {3'd4, 5'h13, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_sideband: grade=%0d poly=%h err=%b rdy=%b expected 4 13 0 0",
                     polyn_grade_out, polyn_red_out, grade_err, in_ready);
        end
        drain();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_handshake: got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_masking();
        int lat;
        run_op(4'hF, 4'hF, 3'd4, 5'h13, lat);
        checks++;
        if (reduc_out !== 8'h55 || lat !== exp_lat(4, 15)) begin
            errors++;
            $display("FAIL mask_m4: got %h lat %0d expected 55 lat %0d", reduc_out, lat, exp_lat(4, 15));
        end
        drain();
        run_op(4'hF, 4'hF, 3'd3, 5'h0B, lat);
        checks++;
        if (reduc_out !== 8'h15 || lat !== 4) begin
            errors++;
            $display("FAIL mask_m3: got %h lat %0d expected 15 lat 4", reduc_out, lat);
        end
        drain();
        run_op(4'h3, 4'h2, 3'd2, 5'h07, lat);
        checks++;
        if (reduc_out !== 8'h06 || lat !== 3) begin
            errors++;
            $display("FAIL mask_m2: got %h lat %0d expected 06 lat 3", reduc_out, lat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(4'h5, 4'h3, 3'd4, 5'h13, lat);
        checks++;
        if (reduc_out !== 8'h0F || lat !== exp_lat(4, 3)) begin
            errors++;
            $display("FAIL bp_product: got %h lat %0d expected 0f lat %0d", reduc_out, lat, exp_lat(4, 3));
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            a_in        = 4'(k);
            b_in        = 4'hF;
            polyn_grade = 3'd2;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, reduc_out, polyn_grade_out} !== {1'b1, 1'b0, 8'h0F, 3'd4}) begin
                errors++;
                $display("FAIL bp_hold_%0d: v=%b r=%b p=%h g=%0d expected 1 0 0f 4",
                         k, out_valid, in_ready, reduc_out, polyn_grade_out);
            end
        end
        // in_valid stays high through the handshake edge; it must not be taken.
        drain();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got %b expected 01", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_overlap: in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_invalid_grade();
        int lat;
        logic [2:0] bad [3];
        bad[0] = 3'd1;
        bad[1] = 3'd5;
        bad[2] = 3'd0;
        for (int k = 0; k < 3; k++) begin
            run_op(4'hF, 4'hF, bad[k], 5'h13, lat);
            checks++;
            if ({reduc_out, grade_err, polyn_grade_out} !== {8'h00, 1'b1, bad[k]} || lat !== 1) begin
                errors++;
                $display("FAIL invalid_m%0d: p=%h err=%b g=%0d lat=%0d expected 00 1 %0d 1",
                         bad[k], reduc_out, grade_err, polyn_grade_out, lat, bad[k]);
            end
            drain();
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        @(negedge clk);
        a_in        = 4'hB;
        b_in        = 4'h6;
        polyn_grade = 3'd4;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, reduc_out, polyn_grade_out} !== {1'b0, 1'b1, 8'h00, 3'd0}) begin
            errors++;
            $display("FAIL abort_state: v=%b r=%b p=%h g=%0d expected 0 1 00 0",
                     out_valid, in_ready, reduc_out, polyn_grade_out);
        end
        run_op(4'h3, 4'h3, 3'd4, 5'h13, lat);
        checks++;
        if (reduc_out !== 8'h05 || lat !== exp_lat(4, 3) || grade_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_followup: p=%h lat=%0d err=%b expected 05 %0d 0",
                     reduc_out, lat, grade_err, exp_lat(4, 3));
        end
        drain();
    endtask

    task automatic test_early_term();
        int lat;
        int exp;
`ifdef GF_CLMUL_EARLY_TERM_EN
        exp = 2;
`else
        exp = 5;
`endif
        run_op(4'h9, 4'h1, 3'd4, 5'h13, lat);
        checks++;
        if (reduc_out !== 8'h09 || lat !== exp) begin
            errors++;
            $display("FAIL early_b1: p=%h lat=%0d expected 09 %0d", reduc_out, lat, exp);
        end
        drain();
        run_op(4'hA, 4'h0, 3'd4, 5'h13, lat);
        checks++;
        if (reduc_out !== 8'h00 || lat !== exp) begin
            errors++;
            $display("FAIL early_b0: p=%h lat=%0d expected 00 %0d", reduc_out, lat, exp);
        end
        drain();
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a_in         = '0;
        b_in         = '0;
        polyn_grade  = '0;
        polyn_red_in = '0;
        test_reset();
        test_basic();
        test_masking();
        test_backpressure();
        test_invalid_grade();
        test_reset_abort();
        test_early_term();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_clmul_seq.md
Name: gf_clmul_seq

Overview:
- Sequential shift-and-XOR carry-less multiplier over GF(2)[x]; the stage directly upstream of the GF(2^m) polynomial reduction stage.
- Multiplies two operands of runtime grade m (2 ≤ m ≤ DATA_WIDTH) one bit per cycle and produces the unreduced 2m-1 bit product, zero-extended to 2*DATA_WIDTH bits.
- Passes grade and primitive polynomial through alongside the product so they stay aligned with it. Ready/valid on both sides.

Parameters:
- DATA_WIDTH, 4, maximum field degree; operand width; product bus is 2*DATA_WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands/grade/polynomial valid
- in_ready  output  1  block can accept; high only in IDLE
- a_in  input  DATA_WIDTH  multiplicand
- b_in  input  DATA_WIDTH  multiplier
- polyn_grade  input  $clog2(DATA_WIDTH)+1  field grade m
- polyn_red_in  input  DATA_WIDTH+1  primitive polynomial, passed through
- out_valid  output  1  product valid, held until accepted
- out_ready  input  1  downstream accepts
- reduc_out  output  2*DATA_WIDTH  product, bits [2m-2:0] significant, rest 0
- polyn_grade_out  output  $clog2(DATA_WIDTH)+1  captured grade
- polyn_red_out  output  DATA_WIDTH+1  captured polynomial
- grade_err  output  1  captured grade was out of range

Behaviour:
- Reset:
  - FSM to IDLE.
  - in_ready=1; out_valid=0; reduc_out=0; polyn_grade_out=0; polyn_red_out=0; grade_err=0.
  - Internal accumulator, shift registers and counter cleared.
- States:
  - IDLE: in_ready=1. in_valid&&in_ready at an edge captures the inputs.
  - MUL: iterate.
  - DONE: out_valid=1.
- Capture:
  - a_sh and b_sh are a_in and b_in with bits ≥ m forced to 0.
  - acc=0.
  - cnt=m.
  - polyn_grade and polyn_red_in are latched to their *_out registers.
- Capture with a valid grade (2 ≤ m ≤ DATA_WIDTH): next state MUL, grade_err=0.
- Capture with an invalid grade (m<2 or m>DATA_WIDTH): next state DONE, acc=0, grade_err=1. No iteration is performed.
- MUL, each cycle:
  - if b_sh[0], acc ^= a_sh (acc is 2*DATA_WIDTH wide, a_sh zero-extended);
  - a_sh <<= 1; b_sh >>= 1; cnt -= 1;
  - the cycle in which cnt goes 1→0 moves to DONE.
- Latency:
  - Valid grade: out_valid rises m+1 edges after the accepting edge (m iteration edges plus the DONE transition folded into the last one).
  - Invalid grade: out_valid rises on the edge after acceptance.
- reduc_out is driven from acc. It is stable and unchanged while out_valid=1.
- DONE:
  - out_valid&&out_ready at an edge → IDLE. out_valid drops and in_ready rises on that same edge.
  - No new input is accepted in the same cycle as the output handshake (no overlap).
  - out_ready low holds DONE indefinitely; all outputs stay frozen.
- in_valid is ignored outside IDLE, and input changes are ignored outside IDLE.
- rst in any state (including mid-MUL or DONE) aborts the operation and restores reset values on that edge; the partial product is discarded.
- rst has priority over any simultaneous handshake.
- Result equals the carry-less product of the masked operands; its degree is at most 2m-2, and bit 2*DATA_WIDTH-1 is always 0.

Optional Feature:
- Macro: GF_CLMUL_EARLY_TERM_EN.
- Defined: in MUL, if the post-shift b_sh is zero, go to DONE immediately regardless of cnt. acc is already final. Latency becomes (index of highest set bit of masked b)+2 edges, with a minimum of 2 edges from acceptance. b=0 with a valid grade finishes in 2 edges.
- Undefined: fixed latency m+1 edges for every valid grade; cnt alone ends MUL.
- Results are bit-identical in both builds.

Test Plan:
- DATA_WIDTH=4, m=4, a=0xB, b=0x6, out_ready=1 → out_valid exactly 5 edges after accept; reduc_out=0x3A; polyn_grade_out=4; grade_err=0.
- m=4, a=0xF, b=0xF → reduc_out=0x55. m=3, a=0xF, b=0xF (bit 3 masked) → reduc_out=0x15, latency 4 edges.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs frozen, in_ready=0, new in_valid ignored. Raise out_ready → one-cycle handshake, then IDLE with in_ready=1.
- Invalid grade m=1 and m=5 → out_valid after 1 edge, reduc_out=0, grade_err=1.
- rst asserted 2 cycles into an m=4 multiply → next cycle IDLE, out_valid=0, reduc_out=0. A following a=0x3, b=0x3 gives reduc_out=0x5 with correct latency.
- With GF_CLMUL_EARLY_TERM_EN, m=4, b=0x1, a=0x9 → reduc_out=0x9, out_valid after 2 edges. Without the macro → same value after 5 edges.
